cpu1_ram_arbiter: RTL and testbench
===================================

CPU1_RAM_ARBITER -- requirements
Module: cpu1_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the shared RAM.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter LOCK_MAX, default 16, max consecutive locked grants to one master.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port freeze  input  1  when high, no new grants are issued.
REQ-007 SHALL have ports m0_address / m1_address  input  ADDR_W  requester word address.
REQ-008 SHALL have ports m0_byteenable / m1_byteenable  input  DATA_W/8  requester byte lanes.
REQ-009 SHALL have ports m0_read / m1_read  input  1  read request.
REQ-010 SHALL have ports m0_write / m1_write  input  1  write request.
REQ-011 SHALL have ports m0_writedata / m1_writedata  input  DATA_W  write data.
REQ-012 SHALL have ports m0_lock / m1_lock  input  1  request to retain grant on next cycle.
REQ-013 SHALL have ports m0_waitrequest / m1_waitrequest  output  1  request not accepted this cycle.
REQ-014 SHALL have ports m0_readdata / m1_readdata  output  DATA_W  read return data.
REQ-015 SHALL have ports m0_readdatavalid / m1_readdatavalid  output  1  read return strobe.
REQ-016 SHALL have port ram_address  output  ADDR_W  to RAM address.
REQ-017 SHALL have port ram_byteenable  output  DATA_W/8  to RAM byteenable.
REQ-018 SHALL have port ram_chipselect  output  1  to RAM chipselect.
REQ-019 SHALL have port ram_write  output  1  to RAM write.
REQ-020 SHALL have port ram_writedata  output  DATA_W  to RAM writedata.
REQ-021 SHALL have port ram_readdata  input  DATA_W  from RAM; valid one cycle after address accepted (registered address, unregistered output).

Function
REQ-022 SHALL define reqN = mN_read | mN_write; at most one master granted per cycle; no grant while freeze=1 or reset=1.
REQ-023 SHALL grant combinationally: single requester wins; both requesting -> master not in last_grant register wins (round-robin).
REQ-024 SHALL override round-robin when last granted master N has mN_lock=1, reqN=1 and lock_cnt < LOCK_MAX-1: N keeps grant.
REQ-025 SHALL increment lock_cnt on each lock-retained grant, clear it on any grant change or idle cycle; at LOCK_MAX-1 the other requester (if any) wins next.
REQ-026 SHALL update last_grant on every grant cycle only; unchanged on idle/frozen cycles.
REQ-027 SHALL drive ram_* from granted master in the grant cycle, ram_chipselect=1; no grant -> ram_chipselect=0, ram_write=0, other ram_* outputs 0.
REQ-028 SHALL drive mN_waitrequest = reqN & ~grantN (zero-wait on grant, 0 when not requesting).
REQ-029 SHALL treat mN_read & mN_write both high as a write; no readdatavalid generated.
REQ-030 SHALL register {rd_valid, rd_owner} at grant of a read; next cycle assert mOwner_readdatavalid=1 for exactly one cycle.
REQ-031 SHALL drive mN_readdata = ram_readdata when mN_readdatavalid=1, else 0.
REQ-032 SHALL sustain one access per cycle: back-to-back reads from either master pipeline with 1-cycle latency each, in order.
REQ-033 SHALL complete an in-flight read while freeze=1 (readdatavalid still asserted next cycle).
REQ-034 SHALL take writes in the grant cycle; no write response.

Reset
REQ-035 SHALL on reset asynchronously set last_grant=1 (m0 wins first tie), lock_cnt=0, rd_valid=0, rd_owner=0.
REQ-036 SHALL during reset hold ram_chipselect=0, ram_write=0, both readdatavalid=0, mN_waitrequest=reqN.
REQ-037 SHALL drop an in-flight read on reset mid-operation: no readdatavalid after reset deassertion.

Verification
REQ-038 SHALL test: after reset, m0/m1 read 0x004/0x008 same cycle -> m0 granted cycle 1, m1 cycle 2; m0_readdatavalid cycle 2, m1_readdatavalid cycle 3.
REQ-039 SHALL test: both continuously write for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; waitrequest low only on owner.
REQ-040 SHALL test: m1_lock=1 with m0 requesting, LOCK_MAX=4 -> m1 granted 4 consecutive cycles, then m0 granted.
REQ-041 SHALL test: m0 write 0xDEADBEEF byteenable 0x3 to 0x3FF, then read -> readdata lower 16 bits 0xBEEF, upper bytes unchanged.
REQ-042 SHALL test: freeze=1 cycle after m0 read grant -> m0_readdatavalid still asserted; m1 request stalled until freeze=0.
REQ-043 SHALL test: reset pulsed cycle after read grant -> no readdatavalid; first tie after reset goes to m0.

Source files
------------

// File: rtl/cpu1_ram_arbiter.sv
// Purpose: two-master arbiter for one shared single-port RAM (round-robin with bounded lock).
// Latency: zero-wait grant; read data returns one cycle after the grant cycle.
// Backpressure: a requester that loses arbitration, or is blocked by freeze, sees waitrequest.
//
// Ports:
//   clk, reset (async, active-high), freeze (blocks new grants)
//   m0_* / m1_*  : requester side (address, byteenable, read, write, writedata, lock,
//                  waitrequest, readdata, readdatavalid)
//   ram_*        : shared RAM side (address, byteenable, chipselect, write, writedata, readdata)
module cpu1_ram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  freeze,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic                  m0_lock,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic                  m1_lock,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  input  logic [DATA_W-1:0]     ram_readdata
);

  // lock_cnt never exceeds LOCK_MAX-1; one spare bit keeps LOCK_MAX=1 legal.
  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX - 1);

  logic             last_grant;   // 0: m0 was granted last, 1: m1
  logic [CNT_W-1:0] lock_cnt;
  logic             rd_valid;
  logic             rd_owner;

  logic req0, req1;
  logic grant0, grant1;
  logic lock_hold0, lock_hold1;
  logic hold_taken;
  logic rd_issue0, rd_issue1;

  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;

    // The previous owner keeps the RAM while it asserts lock, until its
    // budget of consecutive retained grants is spent.
    lock_hold0 = ~last_grant & m0_lock & req0 & (lock_cnt < LOCK_LIM);
    lock_hold1 =  last_grant & m1_lock & req1 & (lock_cnt < LOCK_LIM);

    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!freeze && !reset) begin
      if (lock_hold0) begin
        grant0 = 1'b1;
      end else if (lock_hold1) begin
        grant1 = 1'b1;
      end else if (req0 && req1) begin
        // Tie: whoever was not served last goes next.
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end

    hold_taken = (lock_hold0 & grant0) | (lock_hold1 & grant1);

    // A simultaneous read+write is a write and produces no read return.
    rd_issue0 = grant0 & m0_read & ~m0_write;
    rd_issue1 = grant1 & m1_read & ~m1_write;
  end

  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_write      = 1'b0;
    ram_writedata  = '0;
    ram_chipselect = grant0 | grant1;
    if (grant0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_write      = m0_write;
      ram_writedata  = m0_writedata;
    end else if (grant1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_write      = m1_write;
      ram_writedata  = m1_writedata;
    end
  end

  always_comb begin
    m0_waitrequest   = req0 & ~grant0;
    m1_waitrequest   = req1 & ~grant1;
    m0_readdatavalid = rd_valid & ~rd_owner;
    m1_readdatavalid = rd_valid &  rd_owner;
    m0_readdata      = m0_readdatavalid ? ram_readdata : '0;
    m1_readdata      = m1_readdatavalid ? ram_readdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rd_valid   <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (grant0 | grant1) begin
        last_grant <= grant1;
      end

      // Only a lock-retained grant extends the run; anything else restarts it.
      if (hold_taken) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end else begin
        lock_cnt <= '0;
      end

      // The RAM returns data the cycle after the address is taken, so the
      // owner tag only needs to live for one cycle.
      rd_valid <= rd_issue0 | rd_issue1;
      if (rd_issue0 | rd_issue1) begin
        rd_owner <= rd_issue1;
      end
    end
  end

endmodule

// File: tb/tb_cpu1_ram_arbiter.sv
module tb_cpu1_ram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              freeze;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m1_read, m0_write, m1_write, m0_lock, m1_lock;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect, ram_write;
  logic [DATA_W-1:0] ram_writedata, ram_readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu1_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  // Shared RAM: registered address, byte-lane writes, preloaded with C0DE_<addr>.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_rdq;
  logic              mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= {16'hC0DE, 16'(i)};
    end else if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < BE_W; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_rdq <= mem[ram_address];
      end
    end
  end
  assign ram_readdata = ram_rdq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_lock = 0;
    m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_lock = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic g0, g1;
    reset = 1; freeze = 0; mem_init = 1;
    idle_inputs();
    next_cycle();
    next_cycle();

    // Outputs while reset is held, with requests pending.
    m0_read = 1; m0_address = 10'h004; m0_byteenable = 4'hF;
    m1_write = 1; m1_address = 10'h008;
    @(negedge clk);
    chk1("rst_cs", ram_chipselect, 1'b0);
    chk1("rst_wr", ram_write, 1'b0);
    chk1("rst_m0_wait", m0_waitrequest, 1'b1);
    chk1("rst_m1_wait", m1_waitrequest, 1'b1);
    chk1("rst_m0_rdv", m0_readdatavalid, 1'b0);
    chk1("rst_m1_rdv", m1_readdatavalid, 1'b0);
    idle_inputs();
    next_cycle();
    reset = 0; mem_init = 0;

    // Simultaneous reads after reset: m0 first, then m1, each returns a cycle later.
    m0_read = 1; m0_address = 10'h004; m0_byteenable = 4'hF;
    m1_read = 1; m1_address = 10'h008; m1_byteenable = 4'hF;
    @(negedge clk);
    chk1("tie_c1_cs", ram_chipselect, 1'b1);
    chk("tie_c1_addr", 32'(ram_address), 32'h004);
    chk1("tie_c1_m0_wait", m0_waitrequest, 1'b0);
    chk1("tie_c1_m1_wait", m1_waitrequest, 1'b1);
    next_cycle();
    m0_read = 0;
    @(negedge clk);
    chk("tie_c2_addr", 32'(ram_address), 32'h008);
    chk1("tie_c2_m1_wait", m1_waitrequest, 1'b0);
    chk1("tie_c2_m0_rdv", m0_readdatavalid, 1'b1);
    chk("tie_c2_m0_data", m0_readdata, 32'hC0DE0004);
    chk1("tie_c2_m1_rdv", m1_readdatavalid, 1'b0);
    next_cycle();
    m1_read = 0;
    @(negedge clk);
    chk1("tie_c3_m1_rdv", m1_readdatavalid, 1'b1);
    chk("tie_c3_m1_data", m1_readdata, 32'hC0DE0008);
    chk1("tie_c3_m0_rdv", m0_readdatavalid, 1'b0);
    chk("tie_c3_m0_data", m0_readdata, 32'h0);
    chk1("tie_c3_cs", ram_chipselect, 1'b0);
    next_cycle();

    // Continuous writes from both: strict alternation starting with m0.
    m0_write = 1; m0_address = 10'h010; m0_writedata = 32'h0000_1111; m0_byteenable = 4'hF;
    m1_write = 1; m1_address = 10'h020; m1_writedata = 32'h0000_2222; m1_byteenable = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g0 = (i % 2 == 0);
      chk1($sformatf("rr%0d_m0_wait", i), m0_waitrequest, ~g0);
      chk1($sformatf("rr%0d_m1_wait", i), m1_waitrequest, g0);
      chk1($sformatf("rr%0d_wr", i), ram_write, 1'b1);
      chk("rr_addr", 32'(ram_address), g0 ? 32'h010 : 32'h020);
      next_cycle();
    end
    idle_inputs();

    // Make m0 the last owner so the locked run starts with m1 winning a tie.
    m0_write = 1; m0_address = 10'h030; m0_writedata = 32'h3; m0_byteenable = 4'hF;
    @(negedge clk);
    chk1("pre_lock_m0_wait", m0_waitrequest, 1'b0);
    next_cycle();

    // m1 holds lock with m0 waiting: four m1 grants (LOCK_MAX=4), then m0.
    m1_write = 1; m1_address = 10'h040; m1_writedata = 32'h4; m1_byteenable = 4'hF; m1_lock = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      g1 = (i < 4);
      chk1($sformatf("lock%0d_m1_wait", i), m1_waitrequest, ~g1);
      chk1($sformatf("lock%0d_m0_wait", i), m0_waitrequest, g1);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk1("idle_cs", ram_chipselect, 1'b0);
    next_cycle();

    // Partial-lane write then read back: only the low 16 bits change.
    m0_write = 1; m0_address = 10'h3FF; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'h3;
    @(negedge clk);
    chk1("be_wr", ram_write, 1'b1);
    chk("be_lanes", 32'(ram_byteenable), 32'h3);
    chk("be_wdata", ram_writedata, 32'hDEADBEEF);
    next_cycle();
    m0_write = 0; m0_read = 1; m0_byteenable = 4'hF;
    @(negedge clk);
    chk1("be_rd_cs", ram_chipselect, 1'b1);
    chk1("be_rd_wr", ram_write, 1'b0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk1("be_rdv", m0_readdatavalid, 1'b1);
    chk("be_rdata", m0_readdata, 32'hC0DEBEEF);
    next_cycle();

    // Freeze right after a read grant: read still returns, m1 stalls.
    m0_read = 1; m0_address = 10'h004; m0_byteenable = 4'hF;
    @(negedge clk);
    chk1("frz_grant_m0_wait", m0_waitrequest, 1'b0);
    next_cycle();
    m0_read = 0; freeze = 1;
    m1_read = 1; m1_address = 10'h008; m1_byteenable = 4'hF;
    @(negedge clk);
    chk1("frz_m0_rdv", m0_readdatavalid, 1'b1);
    chk("frz_m0_data", m0_readdata, 32'hC0DE0004);
    chk1("frz_m1_wait", m1_waitrequest, 1'b1);
    chk1("frz_cs", ram_chipselect, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("frz2_m1_wait", m1_waitrequest, 1'b1);
    chk1("frz2_m0_rdv", m0_readdatavalid, 1'b0);
    next_cycle();
    freeze = 0;
    @(negedge clk);
    chk1("unfrz_m1_wait", m1_waitrequest, 1'b0);
    chk("unfrz_addr", 32'(ram_address), 32'h008);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk1("unfrz_m1_rdv", m1_readdatavalid, 1'b1);
    chk("unfrz_m1_data", m1_readdata, 32'hC0DE0008);
    next_cycle();

    // Reset the cycle after an m0 read grant: the return is dropped, and the
    // tie priority is restored to m0 even though m0 was the last owner.
    m0_read = 1; m0_address = 10'h004; m0_byteenable = 4'hF;
    @(negedge clk);
    chk1("mid_grant_m0_wait", m0_waitrequest, 1'b0);
    next_cycle();
    m0_read = 0; reset = 1;
    @(negedge clk);
    chk1("mid_rst_m0_rdv", m0_readdatavalid, 1'b0);
    next_cycle();
    reset = 0;
    @(negedge clk);
    chk1("post_rst_m0_rdv", m0_readdatavalid, 1'b0);
    chk1("post_rst_m1_rdv", m1_readdatavalid, 1'b0);
    next_cycle();
    m0_read = 1; m0_address = 10'h004; m0_byteenable = 4'hF;
    m1_read = 1; m1_address = 10'h008; m1_byteenable = 4'hF;
    @(negedge clk);
    chk1("rtie_m0_wait", m0_waitrequest, 1'b0);
    chk1("rtie_m1_wait", m1_waitrequest, 1'b1);
    next_cycle();
    m0_read = 0;
    @(negedge clk);
    chk1("rtie2_m1_wait", m1_waitrequest, 1'b0);
    chk("rtie2_m0_data", m0_readdata, 32'hC0DE0004);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("rtie3_m1_data", m1_readdata, 32'hC0DE0008);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
